// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexes one shared 4-bit-to-7-segment
// decoder across NUM_DIGITS common-anode digits. Each digit is preceded by
// an all-off gap so the previous digit's segments cannot ghost onto the next.
// New values are double-buffered and swapped only at frame boundaries.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 is never blanked).
module display_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYCLES  = 50000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic                    load_ack,
  output logic [3:0]              nibble,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int MAXC  = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {GAP, DRIVE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] active_q, active_d;
  logic [VAL_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             load_ack_q, load_ack_d;
  logic             frame_done_q, frame_done_d;
  logic             boundary;
  logic             lz_blank;

`ifdef LEADING_ZERO_BLANK_EN
  // Blank when every digit from the top down to the current one is zero,
  // except the rightmost digit so an all-zero value still shows "0".
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((IDX_W'(k) >= idx_q) && (active_q[4*k +: 4] != 4'h0))
        lz_blank = 1'b0;
    end
  end
`else
  // Leading-zero blanking disabled: every driven digit is lit.
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Next-state: scan FSM, digit counter, and the double-buffer handshake.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + 1'b1;
    active_d     = active_q;
    pend_val_d   = pend_val_q;
    pend_d       = pend_q;
    load_ack_d   = 1'b0;
    frame_done_d = 1'b0;
    boundary     = 1'b0;

    case (state_q)
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = GAP;
        cnt_d   = '0;
      end
    endcase

    // Swap uses the value pending before this edge; a load on the same
    // edge becomes the next pending value and is acked one frame later.
    if (boundary) begin
      frame_done_d = 1'b1;
      if (pend_q) begin
        active_d   = pend_val_q;
        pend_d     = 1'b0;
        load_ack_d = 1'b1;
      end
    end

    if (load) begin
      pend_val_d = value;
      pend_d     = 1'b1;
    end
  end

  // State registers; reset drops any pending load without acking it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= GAP;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pin decode purely from registers: no input-to-output path.
  always_comb begin
    digit_sel = '1;
    seg_blank = 1'b1;
    nibble    = active_q[{idx_q, 2'b00} +: 4];
    if (state_q == DRIVE) begin
      digit_sel[idx_q] = 1'b0;
      seg_blank        = lz_blank;
    end
  end

  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared 4-bit-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Per digit: presents the nibble to the decoder and drives one active-low digit enable, with a dead gap between digits to prevent ghosting.
- New display values arrive through a load/ack handshake. They are double-buffered and swapped only at frame boundaries, so no frame ever mixes old and new digits.
- Sits between the value producer (counter/register file) and the decoder plus digit pins on the board.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; range 2..8.
- ON_CYCLES, 50000, clock cycles each digit is driven; must be >= 1.
- GAP_CYCLES, 1000, clock cycles with all digits off before each digit; must be >= 1.

Ports:
- clock  input  1  single system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  request to display value; single-cycle or held.
- value  input  4*NUM_DIGITS  digit k = value[4k+3:4k]; digit 0 is least significant (rightmost).
- load_ack  output  1  one-cycle pulse: pending value has become the active value.
- nibble  output  4  hex digit to the shared decoder's data input.
- seg_blank  output  1  1 = decoder output must be forced off; segments are active-low.
- digit_sel  output  NUM_DIGITS  active-low one-hot digit enables; all ones = all off.
- frame_done  output  1  one-cycle pulse at the start of each new frame.

Behaviour:
- Reset is synchronous and active-high. Clock port is clock, reset port is reset. A reset asserted mid-scan takes effect on the next edge and discards any pending load without acking it.
- Registers and reset values:
  - state = GAP, idx = 0, cnt = 0.
  - active = 0, pending_val = 0, pending = 0.
  - load_ack = 0, frame_done = 0.
  - Resulting outputs: digit_sel = all ones, nibble = 0, seg_blank = 1.
- Outputs are decoded only from registers. There is no combinational input-to-output path.
- FSM, two states:
  - GAP: digit_sel all ones, seg_blank = 1, nibble = active digit idx. cnt counts 0..GAP_CYCLES-1. At GAP_CYCLES-1: cnt <= 0, go to DRIVE.
  - DRIVE: digit_sel[idx] = 0, all other bits 1; seg_blank = 0; nibble = active[4*idx+3:4*idx]. cnt counts 0..ON_CYCLES-1. At ON_CYCLES-1: cnt <= 0, go to GAP, idx <= idx+1.
  - idx wraps from NUM_DIGITS-1 to 0. The wrap edge is the frame boundary.
- Frame period = NUM_DIGITS*(GAP_CYCLES+ON_CYCLES). After reset, digit 0 is first driven at cycle GAP_CYCLES.
- Load handshake:
  - On any edge with load = 1: pending_val <= value, pending <= 1.
  - Repeated loads before a boundary overwrite pending_val; last value wins. Only one load_ack is issued per swap.
- Frame boundary edge:
  - If pending = 1: active <= pending_val, pending <= 0, load_ack <= 1 for one cycle.
  - frame_done <= 1 for one cycle, every frame.
- load asserted on the boundary edge itself:
  - The swap uses the pending_val held before that edge.
  - The new value becomes pending (pending stays 1) and is acked at the next boundary.
- pending = 0 at a boundary: active is unchanged, no load_ack.
- load_ack and frame_done pulses are coincident when a swap occurs.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined, during DRIVE seg_blank = 1 if every active digit from NUM_DIGITS-1 down to idx is 0 and idx != 0. The digit_sel timing is unchanged; digit 0 is never blanked, so 0x0000 shows "0" and 0x0040 shows "40".
- When not defined, seg_blank = 0 in all DRIVE cycles.

Test Plan (NUM_DIGITS=4, ON_CYCLES=4, GAP_CYCLES=1; frame = 20 cycles):
1. Reset held 3 cycles, then released:
   - During reset and the first post-reset cycle: digit_sel = 4'b1111, seg_blank = 1, nibble = 0.
   - Cycles 1-4: digit_sel = 4'b1110. Cycles 6-9: 4'b1101.
   - frame_done pulses at cycle 20.
2. load = 1 for one cycle at cycle 3 with value = 16'h4A7C:
   - Frame 0 still shows 0000.
   - At cycle 20: load_ack = 1, frame_done = 1.
   - Frame 1 nibbles in DRIVE: C, 7, A, 4 for digit_sel 1110, 1101, 1011, 0111.
3. Loads of 16'h1111 at cycle 5 and 16'h2222 at cycle 12:
   - Exactly one load_ack, at cycle 20.
   - Active = 16'h2222.
4. Load 16'h3333 on the boundary edge (cycle 19->20) while 16'h1111 is pending:
   - Frame 1 shows 1111, with load_ack at cycle 20.
   - Frame 2 shows 3333, with load_ack at cycle 40.
5. Reset asserted at cycle 27 while in DRIVE of digit 1 with a load pending:
   - Next cycle: all outputs at reset values.
   - No load_ack is ever issued for the dropped load.
6. LEADING_ZERO_BLANK_EN defined, value = 16'h0040 loaded:
   - seg_blank = 1 during DRIVE of digits 3 and 2.
   - seg_blank = 0 for digit 1 (nibble 4) and digit 0 (nibble 0).
   - Without the macro, seg_blank = 0 for all four digits.
